// File: rtl/z16_regfile_mp.sv
// z16_regfile_mp: 2-read/2-write register file with bypass, optional zero register and clear sequencer
module z16_regfile_mp #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 4,
  parameter int BYPASS         = 1,
  parameter int ZERO_REG       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_wen,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic [ADDR_W-1:0] i_rd2_addr,
  input  logic              i_rd2_wen,
  input  logic [DATA_W-1:0] i_rd2_data,
  output logic              o_ready
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wa, wb, zr, bp;
  assign zr = (ZERO_REG != 0);
  assign bp = (BYPASS != 0);
  assign wa = i_rd_wen && !(zr && i_rd_addr == '0);
  assign wb = i_rd2_wen && !(zr && i_rd2_addr == '0);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt     <= '0;
      o_ready <= (CLEAR_ON_RESET == 0);
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == (ADDR_W+1)'(DEPTH - 1)) begin
        state   <= RUN;
        o_ready <= 1'b1;
      end
    end
  end
  // Port B is written last so it wins an address collision
  always_ff @(posedge i_clk) begin
    if (state == CLEAR) mem[cnt[ADDR_W-1:0]] <= '0;
    else if (!i_rst) begin
      if (wa) mem[i_rd_addr] <= i_rd_data;
      if (wb) mem[i_rd2_addr] <= i_rd2_data;
    end
  end
  always_comb begin
    o_rs1_data = (state == CLEAR) ? '0 :
                 (zr && i_rs1_addr == '0) ? '0 :
                 (bp && i_rd2_wen && i_rd2_addr == i_rs1_addr) ? i_rd2_data :
                 (bp && i_rd_wen && i_rd_addr == i_rs1_addr) ? i_rd_data : mem[i_rs1_addr];
    o_rs2_data = (state == CLEAR) ? '0 :
                 (zr && i_rs2_addr == '0) ? '0 :
                 (bp && i_rd2_wen && i_rd2_addr == i_rs2_addr) ? i_rd2_data :
                 (bp && i_rd_wen && i_rd_addr == i_rs2_addr) ? i_rd_data : mem[i_rs2_addr];
  end
endmodule

// File: tb/tb_z16_regfile_mp.sv
// tb_z16_regfile_mp: scoreboard bench for a default instance and a no-bypass/zero-register instance
module tb_z16_regfile_mp;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 0;
  logic [3:0] rs1 = 0, rs2 = 0, ad = 0, ad2 = 0;
  logic wen = 0, wen2 = 0;
  logic [15:0] d = 0, d2 = 0;
  logic [15:0] a0, b0, a1, b1;
  logic rdy0, rdy1;
  z16_regfile_mp dut (
    .i_clk(clk), .i_rst(rst), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .o_rs1_data(a0), .o_rs2_data(b0), .i_rd_addr(ad), .i_rd_wen(wen), .i_rd_data(d),
    .i_rd2_addr(ad2), .i_rd2_wen(wen2), .i_rd2_data(d2), .o_ready(rdy0));
  z16_regfile_mp #(.BYPASS(0), .ZERO_REG(1)) dz (
    .i_clk(clk), .i_rst(rst), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .o_rs1_data(a1), .o_rs2_data(b1), .i_rd_addr(ad), .i_rd_wen(wen), .i_rd_data(d),
    .i_rd2_addr(ad2), .i_rd2_wen(wen2), .i_rd2_data(d2), .o_ready(rdy1));
  typedef struct packed {
    logic [1:0]  rdy;
    logic [15:0] a0, b0, a1, b1;
  } exp_t;
  exp_t q[$];
  logic [15:0] m [2][16];
  int  clear_left = 0;
  bit  model_valid = 0;
  int  total = 0, bad = 0;
  // Reference: k=0 has bypass, k=1 has no bypass and a hard zero register
  function automatic logic [15:0] mread(input int k, input logic [3:0] a);
    if (clear_left > 0) return 16'h0;
    if (k == 1 && a == 4'd0) return 16'h0;
    if (k == 0 && wen2 && ad2 == a) return d2;
    if (k == 0 && wen && ad == a) return d;
    return m[k][a];
  endfunction
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic cyc(input bit r, input logic [3:0] x1, input logic [3:0] x2,
                     input logic [3:0] wa, input bit we, input logic [15:0] wd,
                     input logic [3:0] wb, input bit we2, input logic [15:0] wd2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rs1 = x1; rs2 = x2; ad = wa; wen = we; d = wd; ad2 = wb; wen2 = we2; d2 = wd2;
    if (model_valid) begin
      e.rdy = (clear_left == 0) ? 2'b11 : 2'b00;
      e.a0 = mread(0, x1); e.b0 = mread(0, x2);
      e.a1 = mread(1, x1); e.b1 = mread(1, x2);
      q.push_back(e);
    end
    if (r) begin
      clear_left = 16;
      model_valid = 1;
      for (int k = 0; k < 2; k++) for (int i = 0; i < 16; i++) m[k][i] = 16'h0;
    end else if (model_valid) begin
      if (clear_left > 0) clear_left--;
      else for (int k = 0; k < 2; k++) begin
        if (we && !(k == 1 && wa == 4'd0)) m[k][wa] = wd;
        if (we2 && !(k == 1 && wb == 4'd0)) m[k][wb] = wd2;
      end
    end
  endtask
  task automatic idle(input logic [3:0] x1, input logic [3:0] x2);
    cyc(0, x1, x2, 4'd0, 0, 16'h0, 4'd0, 0, 16'h0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("ready_a", {15'h0, rdy0}, {15'h0, e.rdy[0]});
        chk("ready_b", {15'h0, rdy1}, {15'h0, e.rdy[1]});
        chk("rs1_a", a0, e.a0);
        chk("rs2_a", b0, e.b0);
        chk("rs1_b", a1, e.a1);
        chk("rs2_b", b1, e.b1);
      end
    end
  end
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (17) idle(5, 5);
    cyc(0, 5, 5, 4'd5, 1, 16'hBEEF, 0, 0, 0);
    idle(5, 5);
    cyc(1, 5, 5, 0, 0, 0, 0, 0, 0);
    repeat (18) idle(5, 5);
    cyc(0, 0, 0, 4'd10, 1, 16'h5555, 0, 0, 0);
    idle(10, 10);
    idle(10, 10);
    cyc(0, 3, 4, 4'd3, 1, 16'h1111, 4'd3, 1, 16'h2222);
    cyc(0, 4, 7, 4'd4, 1, 16'hAAAA, 4'd7, 1, 16'h7777);
    idle(3, 4);
    idle(7, 3);
    cyc(0, 6, 6, 0, 0, 0, 4'd6, 1, 16'hC0DE);
    idle(6, 6);
    cyc(0, 0, 0, 4'd0, 1, 16'hFFFF, 4'd0, 1, 16'hFFFF);
    idle(0, 0);
    cyc(1, 2, 2, 0, 0, 0, 0, 0, 0);
    repeat (8) idle(2, 2);
    cyc(1, 2, 2, 0, 0, 0, 0, 0, 0);
    cyc(0, 2, 2, 4'd2, 1, 16'h1234, 4'd2, 1, 16'h1234);
    repeat (17) idle(2, 2);
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r1, r2, w1, w2;
      bit narrow;
      narrow = $urandom_range(0, 1) == 1;
      r1 = 4'($urandom_range(0, narrow ? 3 : 15));
      r2 = 4'($urandom_range(0, narrow ? 3 : 15));
      w1 = 4'($urandom_range(0, narrow ? 3 : 15));
      w2 = 4'($urandom_range(0, narrow ? 3 : 15));
      cyc($urandom_range(0, 299) == 0, r1, r2, w1, $urandom_range(0, 1) == 1, 16'($urandom),
          w2, $urandom_range(0, 1) == 1, 16'($urandom));
    end
    idle(0, 0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/z16_regfile_mp.md
# z16_regfile_mp

Parametrised multi-port successor to the Z16 register file: two combinational read ports, two prioritised synchronous write ports, optional write-to-read bypass, optional hard-wired zero register, and a reset-driven clear sequencer. It sits between the Z16 decode stage, which drives the read addresses, and the writeback stage, which drives the write ports. The second write port carries load and late results, so the core retires two results per cycle.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- BYPASS, 1, 1 = a read returns data being written in the same cycle
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
- CLEAR_ON_RESET, 1, 1 = the clear sequencer zeroes every register after reset

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock, all state updates on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_rs1_addr  in  ADDR_W  read port 1 address
- i_rs2_addr  in  ADDR_W  read port 2 address
- o_rs1_data  out  DATA_W  read port 1 data, combinational
- o_rs2_data  out  DATA_W  read port 2 data, combinational
- i_rd_addr  in  ADDR_W  write port A address
- i_rd_wen  in  1  write port A enable
- i_rd_data  in  DATA_W  write port A data
- i_rd2_addr  in  ADDR_W  write port B address
- i_rd2_wen  in  1  write port B enable
- i_rd2_data  in  DATA_W  write port B data
- o_ready  out  1  high when the file accepts writes and returns valid reads

## Operation
- FSM states: CLEAR and RUN.
  - When i_rst is sampled high, the FSM enters CLEAR with the clear counter at 0, provided CLEAR_ON_RESET=1. With CLEAR_ON_RESET=0 it enters RUN.
- CLEAR state:
  - Each cycle writes 0 to reg[cnt] and increments cnt.
  - When cnt = DEPTH-1, the FSM moves to RUN on the next edge. The clear takes exactly DEPTH cycles.
  - o_ready = 0 throughout CLEAR. Both read ports output 0.
  - Both write ports are ignored. Dropped writes are not queued.
- RUN state:
  - o_ready = 1.
  - Writes commit on the rising edge when the port's wen is high.
  - If both write ports hit the same address, port B wins and port A's write is discarded.
- Reads: o_rsN_data = reg[i_rsN_addr], subject to these overrides in priority order:
  1. CLEAR state -> 0.
  2. ZERO_REG=1 and address = 0 -> 0.
  3. BYPASS=1 and i_rd2_wen and i_rd2_addr matches -> i_rd2_data.
  4. BYPASS=1 and i_rd_wen and i_rd_addr matches -> i_rd_data.
- ZERO_REG=1: writes to address 0 are dropped on both ports. The clear sequencer still visits address 0 (harmless).
- CLEAR_ON_RESET=0: contents after reset are unspecified (X in simulation). o_ready = 1 from the first edge after reset.
- No arithmetic on data. The counter is ADDR_W+1 bits wide, so the terminal compare does not wrap.

## Timing
- Reset values:
  - o_ready = 0 when CLEAR_ON_RESET=1, otherwise 1.
  - o_rs1_data = o_rs2_data = 0 while in CLEAR.
- Read latency: 0 cycles (combinational from address and current contents).
- Write latency:
  - Data is visible on the read ports in the cycle after the write edge.
  - With BYPASS=1 it is also visible in the same cycle.
- Reset at edge E: the cycle after E is the first CLEAR cycle, and o_ready goes high DEPTH cycles later.
- Reset mid-CLEAR: the counter restarts at 0 and a full DEPTH cycles are required again.
- Reset mid-RUN: the FSM returns to CLEAR and any write presented in the reset cycle is dropped.
- Reset asserted for several cycles: the FSM holds CLEAR with cnt = 0 and writes reg[0] each cycle.

## Test plan
- Reset clear (defaults):
  - Stimulus: pre-load reg 5 = 16'hBEEF, pulse i_rst for 1 cycle.
  - Required: o_ready low for exactly 16 cycles and rising on the 17th; then reg 5 reads 16'h0000 on both ports.
- Write then read:
  - Stimulus: after ready, write A reg 10 = 16'h5555 for one cycle, then set i_rs1_addr = 10 and i_rs2_addr = 10.
  - Required: both ports read 16'h5555 on the next cycle, and the value persists after i_rd_wen drops.
- Dual-write collision:
  - Stimulus: same cycle, A writes reg 3 = 16'h1111 and B writes reg 3 = 16'h2222; in parallel, A writes reg 4 = 16'hAAAA while B writes reg 7 = 16'h7777.
  - Required: reg 3 = 16'h2222; reg 4 = 16'hAAAA and reg 7 = 16'h7777 (independent writes both land).
- Bypass:
  - Stimulus: BYPASS=1, rs1 = 6, B writes reg 6 = 16'hC0DE.
  - Required: o_rs1_data = 16'hC0DE in the same cycle.
  - Same stimulus with BYPASS=0: the old value in the same cycle, 16'hC0DE the next cycle.
- Zero register:
  - Stimulus: ZERO_REG=1, write reg 0 = 16'hFFFF on port A and port B with bypass enabled.
  - Required: reads of reg 0 return 0 in the write cycle and afterwards.
- Reset mid-clear and write during clear:
  - Stimulus: assert i_rst at clear cycle 8; attempt a write of reg 2 = 16'h1234 during CLEAR.
  - Required: o_ready high exactly 16 cycles after the second reset edge; reg 2 reads 0.
